// File: rtl/nadajnik.sv
// UART transmitter: 8 data bits LSB first, STOP_BITS stop bits, single-entry holding register.
// Define NADAJNIK_PARITY_EN to add an even-parity bit after D7.
module nadajnik #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] txData_i,
    input  logic       txStart_i,
    output logic       txREADY,
    output logic       txBUSY,
    output logic       txWYSLANE,
    output logic       TXD_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

`ifdef NADAJNIK_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} stateT;
    logic parityBit;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} stateT;
`endif

    stateT            state;
    logic [CNT_W-1:0] baudCnt;
    logic [2:0]       bitCnt;
    logic             stopCnt;
    logic [7:0]       shiftReg;
    logic [7:0]       holdReg;
    logic             bitDone;
    logic             lastStop;
    logic             loadNow;

    assign bitDone  = (baudCnt == LAST_CNT);
    assign lastStop = (STOP_BITS == 1) ? 1'b1 : stopCnt;
    // A queued byte starts either from idle or straight out of the last stop-bit cycle.
    assign loadNow  = !txREADY &&
                      ((state == IDLE) || ((state == STOP) && bitDone && lastStop));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            baudCnt   <= '0;
            bitCnt    <= '0;
            stopCnt   <= 1'b0;
            shiftReg  <= '0;
            holdReg   <= '0;
            txREADY   <= 1'b1;
            txBUSY    <= 1'b0;
            txWYSLANE <= 1'b0;
            TXD_o     <= 1'b1;
`ifdef NADAJNIK_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else begin
            txWYSLANE <= 1'b0;
            if (txStart_i && txREADY) begin
                holdReg <= txData_i;
                txREADY <= 1'b0;
            end
            if (loadNow) begin
                state    <= START;
                shiftReg <= holdReg;
`ifdef NADAJNIK_PARITY_EN
                parityBit <= ^holdReg;
`endif
                txREADY  <= 1'b1;
                txBUSY   <= 1'b1;
                TXD_o    <= 1'b0;
                baudCnt  <= '0;
            end else begin
                case (state)
                    IDLE: TXD_o <= 1'b1;
                    START: begin
                        if (bitDone) begin
                            state   <= DATA;
                            baudCnt <= '0;
                            bitCnt  <= '0;
                            TXD_o   <= shiftReg[0];
                        end else begin
                            baudCnt <= baudCnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bitDone) begin
                            baudCnt <= '0;
                            if (bitCnt == 3'd7) begin
`ifdef NADAJNIK_PARITY_EN
                                state <= PARITY;
                                TXD_o <= parityBit;
`else
                                state   <= STOP;
                                TXD_o   <= 1'b1;
                                stopCnt <= 1'b0;
`endif
                            end else begin
                                bitCnt   <= bitCnt + 3'd1;
                                shiftReg <= {1'b0, shiftReg[7:1]};
                                TXD_o    <= shiftReg[1];
                            end
                        end else begin
                            baudCnt <= baudCnt + 1'b1;
                        end
                    end
`ifdef NADAJNIK_PARITY_EN
                    PARITY: begin
                        if (bitDone) begin
                            state   <= STOP;
                            baudCnt <= '0;
                            TXD_o   <= 1'b1;
                            stopCnt <= 1'b0;
                        end else begin
                            baudCnt <= baudCnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (bitDone) begin
                            baudCnt <= '0;
                            if (lastStop) begin
                                state  <= IDLE;
                                txBUSY <= 1'b0;
                            end else begin
                                stopCnt <= 1'b1;
                            end
                        end else begin
                            baudCnt <= baudCnt + 1'b1;
                            // Registered pulse lands on the final cycle of the last stop bit.
                            if (lastStop && (baudCnt == PRE_LAST))
                                txWYSLANE <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
